median_window_feeder: RTL and testbench
=======================================

Name: median_window_feeder

Overview:
- Upstream stage of the 9-input serial median core.
- Accepts a raster pixel stream, keeps the last three image rows, and for every interior pixel serialises the 3x3 neighbourhood into the core (9 cycles, DSI high).
- Waits for the core's DSO, captures the median, emits it on a valid-strobed output, then pulses the core's reset so the core is ready for the next window.
- Border pixels (first/last row and column) produce no output: one frame yields (IMG_W-2)*(IMG_H-2) medians.

Parameters:
- width, 8, pixel bit width
- IMG_W, 16, pixels per row (>=3)
- IMG_H, 16, rows per frame (>=3)

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- PIX_IN  in  width  input pixel, raster order
- PIX_VALID  in  1  PIX_IN valid
- PIX_READY  out  1  feeder can accept a pixel
- MED_DI  out  width  pixel to core DI
- MED_DSI  out  1  to core DSI; high for exactly 9 consecutive cycles per window
- MED_nRST  out  1  active-low reset to core
- MED_DO  in  width  core median output
- MED_DSO  in  1  core result-valid (level, held until core reset)
- OUT_PIX  out  width  captured median
- OUT_VALID  out  1  one-cycle strobe, OUT_PIX valid
- FRAME_DONE  out  1  one-cycle strobe with last OUT_VALID of a frame

Behaviour:
- Single clock, rising edge. Asynchronous, active-low nRST.
- Reset values:
  - state=FILL, row=0, col=0.
  - PIX_READY=1 (combinational from state).
  - MED_DSI=0, MED_DI=0.
  - OUT_PIX=0, OUT_VALID=0, FRAME_DONE=0.
  - MED_nRST=0 while nRST=0; MED_nRST = nRST AND NOT(state==CRST).
- Line store: 3 x IMG_W registers indexed by row mod 3 and col. The buffer contents are not reset.
- Accept rule: pixel accepted at an edge where PIX_VALID && PIX_READY. It is written at (row mod 3, col), then col increments; at col=IMG_W-1, col wraps to 0 and row increments; at (IMG_H-1, IMG_W-1), row wraps to 0.
- State FILL: PIX_READY=1. If the accepted pixel has row>=2 and col>=2, latch wr=row, wc=col and go to SEND; otherwise stay in FILL.
- State SEND: PIX_READY=0, MED_DSI=1, 9 cycles, k=0..8.
  - MED_DI = buf[(wr-2+k/3) mod 3][wc-2+k%3], i.e. row-major from the top-left of the window.
  - After k=8, go to WAIT. MED_DSI falls the cycle after k=8.
  - First SEND cycle is the cycle after the accepting edge; the pixel written at that edge must be readable.
- State WAIT: PIX_READY=0, MED_DSI=0. On the edge where MED_DSO=1:
  - OUT_PIX<=MED_DO, OUT_VALID<=1 for one cycle.
  - FRAME_DONE<=1 for one cycle if (wr,wc)=(IMG_H-1,IMG_W-1).
  - Go to CRST.
  - No timeout; WAIT holds indefinitely.
- State CRST: one cycle with MED_nRST=0, then FILL.
- Latency, per window: 1 accept edge + 9 SEND + core latency + 1 capture + 1 CRST before PIX_READY returns.
- The window never reads a slot overwritten in the same frame window: the write at (row,col) replaces row-3 data only.
- Frame boundary: row/col wrap to 0; rows 0-1 of the new frame generate no windows. Old buffer data is never used because row<2 gates SEND.
- PIX_VALID low in FILL: nothing changes. PIX_VALID while PIX_READY=0: ignored, pixel must be held by upstream.
- Stray MED_DSO in FILL/SEND: ignored.
- Reset mid-operation: all state, counters and strobes return to reset values immediately. MED_nRST goes low, so the core is also cleared. A partially delivered frame is discarded.

Test Plan:
- IMG_W=4, IMG_H=4, pixels 0..15 streamed back-to-back, bench core model (DSO 20 cycles after 9th DSI, DO = true median) -> OUT_PIX sequence 5,6,9,10; FRAME_DONE only with the 10; exactly 4 OUT_VALID pulses.
- Same frame, check the first window's MED_DI over its 9 DSI-high cycles -> 0,1,2,4,5,6,8,9,10; MED_DSI high exactly 9 consecutive cycles; PIX_READY=0 from the cycle after pixel 10 is accepted until after CRST.
- CRST check -> MED_nRST low for exactly one cycle after each OUT_VALID, high otherwise (nRST=1).
- Two back-to-back 4x4 frames, second frame pixels 100..115 -> outputs 5,6,9,10,105,106,109,110; second FRAME_DONE on 110; no window emitted during rows 0-1 of frame 2.
- PIX_VALID toggled 1/0 every cycle plus a 50-cycle core stall -> same medians; no pixel lost or duplicated.
- nRST pulsed low during WAIT of the 2nd window, then a fresh frame 0..15 -> all outputs at reset values; the next OUT_PIX sequence is 5,6,9,10.

Source files
------------

// File: rtl/median_window_feeder.sv
// Raster-to-window feeder for the 9-input serial median core: buffers three rows,
// streams each interior 3x3 neighbourhood into the core and collects the median.
`timescale 1ns/1ps
module median_window_feeder #(
    parameter int unsigned width = 8,
    parameter int unsigned IMG_W = 16,
    parameter int unsigned IMG_H = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [width-1:0] PIX_IN,
    input  logic             PIX_VALID,
    output logic             PIX_READY,
    output logic [width-1:0] MED_DI,
    output logic             MED_DSI,
    output logic             MED_nRST,
    input  logic [width-1:0] MED_DO,
    input  logic             MED_DSO,
    output logic [width-1:0] OUT_PIX,
    output logic             OUT_VALID,
    output logic             FRAME_DONE
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_CRST = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [RW-1:0]    row_q, row_d, wr_q, wr_d;
    logic [CW-1:0]    col_q, col_d, wc_q, wc_d;
    logic [1:0]       slot_q, slot_d, ws_q, ws_d;
    logic [1:0]       kr_q, kr_d, kc_q, kc_d;
    logic [width-1:0] di_q, di_d, out_pix_q, out_pix_d;
    logic             dsi_q, dsi_d, out_valid_q, out_valid_d, frame_done_q, frame_done_d;

    logic [width-1:0] line_mem [3][IMG_W];

    logic             accept_c;
    logic [1:0]       kr_nxt_c, kc_nxt_c, win_slot_c;
    logic [CW-1:0]    win_col_c, fill_col_c;

    function automatic logic [1:0] inc3(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Line-store slot holding window row r, given the slot of the window's bottom row
    function automatic logic [1:0] slot_of(input logic [1:0] bottom, input logic [1:0] r);
        case (r)
            2'd0:    return inc3(bottom);
            2'd1:    return inc3(inc3(bottom));
            default: return bottom;
        endcase
    endfunction

    assign accept_c   = PIX_VALID && (state_q == S_FILL);
    assign kc_nxt_c   = (kc_q == 2'd2) ? 2'd0 : kc_q + 2'd1;
    assign kr_nxt_c   = (kc_q == 2'd2) ? kr_q + 2'd1 : kr_q;
    assign win_slot_c = slot_of(ws_q, kr_nxt_c);
    assign win_col_c  = wc_q - CW'(2) + CW'(kc_nxt_c);
    assign fill_col_c = col_q - CW'(2);

    always_ff @(posedge CLK) begin
        if (accept_c) begin
            line_mem[slot_q][col_q] <= PIX_IN;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        slot_d       = slot_q;
        wr_d         = wr_q;
        wc_d         = wc_q;
        ws_d         = ws_q;
        kr_d         = kr_q;
        kc_d         = kc_q;
        di_d         = di_q;
        dsi_d        = dsi_q;
        out_pix_d    = out_pix_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_FILL: begin
                if (PIX_VALID) begin
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(IMG_H - 1)) begin
                            row_d  = '0;
                            slot_d = 2'd0;
                        end else begin
                            row_d  = row_q + RW'(1);
                            slot_d = inc3(slot_q);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    // First window word is registered here; it never touches the slot being written
                    if (row_q >= RW'(2) && col_q >= CW'(2)) begin
                        state_d = S_SEND;
                        wr_d    = row_q;
                        wc_d    = col_q;
                        ws_d    = slot_q;
                        kr_d    = 2'd0;
                        kc_d    = 2'd0;
                        dsi_d   = 1'b1;
                        di_d    = line_mem[inc3(slot_q)][fill_col_c];
                    end
                end
            end
            S_SEND: begin
                if (kr_q == 2'd2 && kc_q == 2'd2) begin
                    state_d = S_WAIT;
                    dsi_d   = 1'b0;
                    di_d    = '0;
                end else begin
                    kr_d = kr_nxt_c;
                    kc_d = kc_nxt_c;
                    di_d = line_mem[win_slot_c][win_col_c];
                end
            end
            S_WAIT: begin
                if (MED_DSO) begin
                    state_d      = S_CRST;
                    out_pix_d    = MED_DO;
                    out_valid_d  = 1'b1;
                    frame_done_d = (wr_q == RW'(IMG_H - 1)) && (wc_q == CW'(IMG_W - 1));
                end
            end
            S_CRST:  state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_FILL;
            row_q        <= '0;
            col_q        <= '0;
            slot_q       <= 2'd0;
            wr_q         <= '0;
            wc_q         <= '0;
            ws_q         <= 2'd0;
            kr_q         <= 2'd0;
            kc_q         <= 2'd0;
            di_q         <= '0;
            dsi_q        <= 1'b0;
            out_pix_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            slot_q       <= slot_d;
            wr_q         <= wr_d;
            wc_q         <= wc_d;
            ws_q         <= ws_d;
            kr_q         <= kr_d;
            kc_q         <= kc_d;
            di_q         <= di_d;
            dsi_q        <= dsi_d;
            out_pix_q    <= out_pix_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign PIX_READY  = (state_q == S_FILL);
    assign MED_nRST   = nRST && (state_q != S_CRST);
    assign MED_DI     = di_q;
    assign MED_DSI    = dsi_q;
    assign OUT_PIX    = out_pix_q;
    assign OUT_VALID  = out_valid_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder on a 4x4 image with a behavioural median core.
`timescale 1ns/1ps
module tb_median_window_feeder;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = 4;
    localparam int unsigned IH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [W-1:0] med_di;
    logic         med_dsi;
    logic         med_nrst;
    logic [W-1:0] med_do;
    logic         med_dso;
    logic [W-1:0] out_pix;
    logic         out_valid;
    logic         frame_done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] outs[$];
    logic         fds[$];
    logic [W-1:0] di_log[$];
    int dsi_run = 0, dsi_bad = 0, windows = 0, crst_bad = 0, nrst_low = 0, ready_bad = 0, fd_bad = 0;
    int stall = 20;
    int gap = 0;

    median_window_feeder #(.width(W), .IMG_W(IW), .IMG_H(IH)) dut (
        .CLK(clk), .nRST(rst_n), .PIX_IN(pix_in), .PIX_VALID(pix_valid), .PIX_READY(pix_ready),
        .MED_DI(med_di), .MED_DSI(med_dsi), .MED_nRST(med_nrst), .MED_DO(med_do), .MED_DSO(med_dso),
        .OUT_PIX(out_pix), .OUT_VALID(out_valid), .FRAME_DONE(frame_done)
    );

    always #5 clk = ~clk;

    // Core model: collects 9 DSI words, raises DSO with the true median `stall` cycles later
    logic [W-1:0] win [9];
    int wcnt = 0, tmr = 0;
    bit armed = 0;
    logic [W-1:0] med_val;

    function automatic logic [W-1:0] med9(input logic [W-1:0] a [9]);
        logic [W-1:0] s [9];
        logic [W-1:0] t;
        s = a;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        return s[4];
    endfunction

    always @(posedge clk or negedge med_nrst) begin
        if (!med_nrst) begin
            wcnt = 0; tmr = 0; armed = 0;
            med_dso <= 1'b0;
            med_do  <= '0;
        end else if (med_dsi && wcnt < 9) begin
            win[wcnt] = med_di;
            wcnt++;
            if (wcnt == 9) begin med_val = med9(win); armed = 1; tmr = 0; end
        end else if (armed && !med_dso) begin
            tmr++;
            if (tmr >= stall) begin med_dso <= 1'b1; med_do <= med_val; end
        end
    end

    // Output/handshake monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (med_dsi) begin
                dsi_run++;
                di_log.push_back(med_di);
            end else if (dsi_run != 0) begin
                if (dsi_run != 9) dsi_bad++;
                windows++;
                dsi_run = 0;
            end
            if (med_nrst !== !out_valid) crst_bad++;
            if (!med_nrst) nrst_low++;
            if (out_valid && pix_ready) ready_bad++;
            if (frame_done && !out_valid) fd_bad++;
            if (out_valid) begin outs.push_back(out_pix); fds.push_back(frame_done); end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_pix(input logic [W-1:0] v);
        int n = 0;
        pix_in = v;
        pix_valid = 1'b1;
        @(negedge clk);
        while (!pix_ready && n < 1000) begin @(negedge clk); n++; end
        if (!pix_ready) begin
            checks++; errors++;
            $error("FAIL accept_timeout observed=%0d expected=1", pix_ready);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < 16; i++) send_pix(W'(base + i));
    endtask

    task automatic wait_outs(input int n);
        int c = 0;
        while (outs.size() < n && c < 3000) begin @(posedge clk); #1; c++; end
        chk("out_count_wait", outs.size(), n);
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, pix_ready, 1);
        chk({tag, "_dsi"}, med_dsi, 0);
        chk({tag, "_di"}, med_di, 0);
        chk({tag, "_out_pix"}, out_pix, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_med_nrst"}, med_nrst, 0);
    endtask

    logic [W-1:0] exp_di [9] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    logic [W-1:0] exp_med [4] = '{8'd5, 8'd6, 8'd9, 8'd10};

    initial begin
        rst_n = 1'b0; pix_valid = 1'b0; pix_in = '0;
        wait_cyc(3);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_med_nrst", med_nrst, 1);
        chk("release_ready", pix_ready, 1);
        @(posedge clk); #1;

        // Frame 0..15 back-to-back
        for (int i = 0; i < 16; i++) begin
            send_pix(W'(i));
            if (i == 10) begin
                chk("ready_low_after_px10", pix_ready, 0);
                wait_cyc(14);
                chk("ready_low_in_wait", pix_ready, 0);
            end
        end
        wait_outs(4);
        for (int i = 0; i < 9; i++) chk($sformatf("win0_di%0d", i), di_log[i], exp_di[i]);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("f1_med%0d", i), outs[i], exp_med[i]);
            chk($sformatf("f1_fd%0d", i), fds[i], (i == 3) ? 1 : 0);
        end
        wait_cyc(5);
        chk("f1_windows", windows, 4);
        chk("f1_nrst_low", nrst_low, 4);
        chk("f1_dsi_bad", dsi_bad, 0);
        chk("f1_crst_bad", crst_bad, 0);

        // Second frame 100..115; rows 0-1 must emit nothing
        for (int i = 0; i < 8; i++) send_pix(W'(100 + i));
        wait_cyc(5);
        chk("f2_rows01_outs", outs.size(), 4);
        chk("f2_rows01_windows", windows, 4);
        for (int i = 8; i < 16; i++) send_pix(W'(100 + i));
        wait_outs(8);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("f2_med%0d", i), outs[4 + i], exp_med[i] + 8'd100);
            chk($sformatf("f2_fd%0d", i), fds[4 + i], (i == 3) ? 1 : 0);
        end

        // Toggled PIX_VALID and a 50-cycle core stall
        stall = 50; gap = 1;
        send_frame(0);
        gap = 0;
        wait_outs(12);
        stall = 20;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("f3_med%0d", i), outs[8 + i], exp_med[i]);
            chk($sformatf("f3_fd%0d", i), fds[8 + i], (i == 3) ? 1 : 0);
        end
        wait_cyc(100);
        chk("f3_no_extra_outs", outs.size(), 12);
        chk("f3_windows", windows, 12);

        // Reset during WAIT of the second window, then a fresh frame
        for (int i = 0; i < 12; i++) send_pix(W'(i));
        wait_cyc(14);
        chk("pre_reset_outs", outs.size(), 13);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        send_frame(0);
        wait_outs(17);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("f4_med%0d", i), outs[13 + i], exp_med[i]);
            chk($sformatf("f4_fd%0d", i), fds[13 + i], (i == 3) ? 1 : 0);
        end
        wait_cyc(50);
        chk("final_outs", outs.size(), 17);
        chk("final_windows", windows, 18);
        chk("final_nrst_low", nrst_low, 17);
        chk("final_dsi_bad", dsi_bad, 0);
        chk("final_crst_bad", crst_bad, 0);
        chk("final_ready_bad", ready_bad, 0);
        chk("final_fd_bad", fd_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
